head_table_lookup: RTL and testbench

HEAD_TABLE_LOOKUP -- requirements
Module: head_table_lookup

---
 rtl/head_table_lookup.sv | 141 ++++++++++++++
 tb/tb_head_table_lookup.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/head_table_lookup.sv
// Head-table lookup stage: per-bucket {head_ptr, ptr_val} RAM read through a
// 3-stage pipeline into a credit-controlled output FIFO, kept coherent with table writes.
module head_table_lookup #(
  parameter int BUCKET_WIDTH   = 10,
  parameter int HEAD_PTR_WIDTH = 10,
  parameter int PDATA_WIDTH    = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PDATA_WIDTH-1:0]    pdata_in_i,
  input  logic [BUCKET_WIDTH-1:0]   bucket_in_i,
  input  logic                      pdata_in_valid_i,
  output logic                      pdata_in_ready_o,
  output logic [PDATA_WIDTH-1:0]    pdata_out_o,
  output logic [BUCKET_WIDTH-1:0]   bucket_out_o,
  output logic [HEAD_PTR_WIDTH-1:0] head_ptr_o,
  output logic                      head_ptr_val_o,
  output logic                      pdata_out_valid_o,
  input  logic                      pdata_out_ready_i,
  input  logic [BUCKET_WIDTH-1:0]   ht_wr_addr_i,
  input  logic [HEAD_PTR_WIDTH-1:0] ht_wr_data_ptr_i,
  input  logic                      ht_wr_data_ptr_val_i,
  input  logic                      ht_wr_en_i
);

  localparam int TABLE_DEPTH = 2 ** BUCKET_WIDTH;
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = AW + 1;
  localparam int EW          = HEAD_PTR_WIDTH + 1;

  logic [EW-1:0] mem [0:TABLE_DEPTH-1];
  logic [EW-1:0] rd_q;
  logic [EW-1:0] wr_word;

  logic                    s1_valid_q, s2_valid_q;
  logic [PDATA_WIDTH-1:0]  s1_pdata_q, s2_pdata_q;
  logic [BUCKET_WIDTH-1:0] s1_bucket_q, s2_bucket_q;
  logic [EW-1:0]           s2_word_q, s2_word_d, push_word;

  logic [PDATA_WIDTH-1:0]  fifo_pdata_q  [0:FIFO_DEPTH-1];
  logic [BUCKET_WIDTH-1:0] fifo_bucket_q [0:FIFO_DEPTH-1];
  logic [EW-1:0]           fifo_word_q   [0:FIFO_DEPTH-1];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d, credit_q, credit_d;

  logic accept, push, pop;

  assign wr_word = {ht_wr_data_ptr_i, ht_wr_data_ptr_val_i};

  // Table RAM with write-first forwarding into the read register.
  always_ff @(posedge clk_i) begin
    if (ht_wr_en_i) begin
      mem[ht_wr_addr_i] <= wr_word;
    end
    if (ht_wr_en_i && (ht_wr_addr_i == bucket_in_i)) begin
      rd_q <= wr_word;
    end else begin
      rd_q <= mem[bucket_in_i];
    end
  end

  assign pdata_in_ready_o  = (credit_q < CW'(FIFO_DEPTH));
  assign accept            = pdata_in_valid_i && pdata_in_ready_o;
  assign pdata_out_valid_o = (count_q != '0);
  assign pop               = pdata_out_valid_o && pdata_out_ready_i;
  assign push              = s2_valid_q;

  // Writes landing while a beat is in flight patch the carried pointer.
  assign s2_word_d = (ht_wr_en_i && (ht_wr_addr_i == s1_bucket_q)) ? wr_word : rd_q;
  assign push_word = (ht_wr_en_i && (ht_wr_addr_i == s2_bucket_q)) ? wr_word : s2_word_q;

  always_comb begin
    count_d  = count_q;
    credit_d = credit_q + CW'(accept) - CW'(pop);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_pdata_q  <= '0;
      s1_bucket_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_pdata_q  <= '0;
      s2_bucket_q <= '0;
      s2_word_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      credit_q    <= '0;
    end else begin
      s1_valid_q  <= accept;
      s1_pdata_q  <= pdata_in_i;
      s1_bucket_q <= bucket_in_i;
      s2_valid_q  <= s1_valid_q;
      s2_pdata_q  <= s1_pdata_q;
      s2_bucket_q <= s1_bucket_q;
      s2_word_q   <= s2_word_d;
      count_q     <= count_d;
      credit_q    <= credit_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Every buffered entry snoops the write port so the head stays coherent.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pdata_q[i]  <= '0;
        fifo_bucket_q[i] <= '0;
        fifo_word_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && (wr_ptr_q == i[AW-1:0])) begin
          fifo_pdata_q[i]  <= s2_pdata_q;
          fifo_bucket_q[i] <= s2_bucket_q;
          fifo_word_q[i]   <= push_word;
        end else if (ht_wr_en_i && (ht_wr_addr_i == fifo_bucket_q[i])) begin
          fifo_word_q[i] <= wr_word;
        end
      end
    end
  end

  assign pdata_out_o    = fifo_pdata_q[rd_ptr_q];
  assign bucket_out_o   = fifo_bucket_q[rd_ptr_q];
  assign head_ptr_o     = fifo_word_q[rd_ptr_q][EW-1:1];
  assign head_ptr_val_o = fifo_word_q[rd_ptr_q][0];

endmodule

// File: tb/tb_head_table_lookup.sv
// Randomised scoreboard bench for head_table_lookup: a negedge monitor compares
// every presented beat against an in-order queue and a reference head table.
module tb_head_table_lookup;

  localparam int BW  = 10;
  localparam int PW  = 10;
  localparam int DW  = 64;
  localparam int FD  = 4;
  localparam int TD  = 2 ** BW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] pdata_in_i;
  logic [BW-1:0] bucket_in_i;
  logic          pdata_in_valid_i;
  logic          pdata_in_ready_o;
  logic [DW-1:0] pdata_out_o;
  logic [BW-1:0] bucket_out_o;
  logic [PW-1:0] head_ptr_o;
  logic          head_ptr_val_o;
  logic          pdata_out_valid_o;
  logic          pdata_out_ready_i;
  logic [BW-1:0] ht_wr_addr_i;
  logic [PW-1:0] ht_wr_data_ptr_i;
  logic          ht_wr_data_ptr_val_i;
  logic          ht_wr_en_i;

  head_table_lookup #(
    .BUCKET_WIDTH(BW), .HEAD_PTR_WIDTH(PW), .PDATA_WIDTH(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pdata_in_i(pdata_in_i), .bucket_in_i(bucket_in_i),
    .pdata_in_valid_i(pdata_in_valid_i), .pdata_in_ready_o(pdata_in_ready_o),
    .pdata_out_o(pdata_out_o), .bucket_out_o(bucket_out_o),
    .head_ptr_o(head_ptr_o), .head_ptr_val_o(head_ptr_val_o),
    .pdata_out_valid_o(pdata_out_valid_o), .pdata_out_ready_i(pdata_out_ready_i),
    .ht_wr_addr_i(ht_wr_addr_i), .ht_wr_data_ptr_i(ht_wr_data_ptr_i),
    .ht_wr_data_ptr_val_i(ht_wr_data_ptr_val_i), .ht_wr_en_i(ht_wr_en_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pdata;
    logic [BW-1:0] bucket;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW:0]   tbl [TD];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            in_flight = 0;
  int            acc_count = 0;
  bit            lat_flag = 0;
  bit            prev_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything sampled at negedge, decisions apply to the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      checks++;
      if (pdata_out_valid_o !== 1'b0 || pdata_out_o !== '0 || head_ptr_o !== '0 ||
          head_ptr_val_o !== 1'b0 || bucket_out_o !== '0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%0b pdata=%h ptr=%h val=%0b required all 0",
                 pdata_out_valid_o, pdata_out_o, head_ptr_o, head_ptr_val_o);
      end
      exp_q.delete();
      in_flight = 0;
      prev_hold = 0;
    end else begin
      checks++;
      if (pdata_in_ready_o !== (in_flight < FD)) begin
        errors++;
        $display("FAIL in_ready: got %0b required %0b (in_flight=%0d)",
                 pdata_in_ready_o, (in_flight < FD), in_flight);
      end
      if (pdata_out_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: pdata=%h bucket=%0d required no beat",
                   pdata_out_o, bucket_out_o);
        end else begin
          e = exp_q[0];
          checks++;
          if (pdata_out_o !== e.pdata || bucket_out_o !== e.bucket) begin
            errors++;
            $display("FAIL order: got pdata=%h bucket=%0d required pdata=%h bucket=%0d",
                     pdata_out_o, bucket_out_o, e.pdata, e.bucket);
          end
          checks++;
          if ({head_ptr_o, head_ptr_val_o} !== tbl[e.bucket]) begin
            errors++;
            $display("FAIL head_ptr: bucket=%0d got ptr=%h val=%0b required ptr=%h val=%0b",
                     e.bucket, head_ptr_o, head_ptr_val_o,
                     tbl[e.bucket][PW:1], tbl[e.bucket][0]);
          end
          if (e.lat && pdata_out_ready_i) begin
            checks++;
            if (cyc - e.acc != 2) begin
              errors++;
              $display("FAIL latency: valid %0d edges after accept required 2",
                       cyc - e.acc);
            end
          end
        end
      end else if (prev_hold) begin
        checks++;
        errors++;
        $display("FAIL hold: valid dropped while ready low, got 0 required 1");
      end
      prev_hold = (pdata_out_valid_o === 1'b1) && !pdata_out_ready_i;
      if (pdata_out_valid_o === 1'b1 && pdata_out_ready_i && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        in_flight--;
      end
      if (pdata_in_valid_i && pdata_in_ready_o) begin
        e.pdata  = pdata_in_i;
        e.bucket = bucket_in_i;
        e.acc    = cyc + 1;
        e.lat    = lat_flag;
        exp_q.push_back(e);
        in_flight++;
        acc_count++;
      end
      if (ht_wr_en_i) tbl[ht_wr_addr_i] = {ht_wr_data_ptr_i, ht_wr_data_ptr_val_i};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int b, input int p, input bit v);
    ht_wr_en_i = 1'b1;
    ht_wr_addr_i = BW'(b);
    ht_wr_data_ptr_i = PW'(p);
    ht_wr_data_ptr_val_i = v;
    tick();
    ht_wr_en_i = 1'b0;
  endtask

  task automatic lookup(input int b, input bit lat);
    pdata_in_valid_i = 1'b1;
    bucket_in_i = BW'(b);
    pdata_in_i = {$urandom, $urandom};
    lat_flag = lat;
    tick();
    pdata_in_valid_i = 1'b0;
    lat_flag = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (pdata_out_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pdata_out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid got 0 required 1 within 20 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    rst_i = 1'b1;
    pdata_in_i = '0; bucket_in_i = '0; pdata_in_valid_i = 1'b0;
    pdata_out_ready_i = 1'b1;
    ht_wr_addr_i = '0; ht_wr_data_ptr_i = '0; ht_wr_data_ptr_val_i = 1'b0; ht_wr_en_i = 1'b0;
    for (int i = 0; i < TD; i++) tbl[i] = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (pdata_in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b required 1", pdata_in_ready_o);
    end

    // Table initialisation as data_table would do it, with random contents.
    for (int b = 0; b < TD; b++) do_write(b, $urandom, 1'($urandom));

    // Basic lookup with latency check.
    do_write(5, 'h12, 1'b1);
    tick();
    lookup(5, 1'b1);
    repeat (6) tick();
    $display("lookup bucket 5 done, acc_count=%0d", acc_count);

    // Back-pressure: only FIFO_DEPTH beats get in.
    pdata_out_ready_i = 1'b0;
    a0 = acc_count;
    for (int i = 0; i < 10; i++) begin
      pdata_in_valid_i = 1'b1;
      bucket_in_i = BW'($urandom_range(0, 15));
      pdata_in_i = {$urandom, $urandom};
      tick();
    end
    pdata_in_valid_i = 1'b0;
    checks++;
    if (acc_count - a0 != FD) begin
      errors++;
      $display("FAIL backpressure_accepts: got %0d required %0d", acc_count - a0, FD);
    end
    checks++;
    if (pdata_in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_ready: got %0b required 0", pdata_in_ready_o);
    end
    pdata_out_ready_i = 1'b1;
    repeat (10) tick();
    $display("backpressure burst drained, acc_count=%0d", acc_count);

    // Write one cycle after acceptance must reach the beat.
    do_write(7, 'h3, 1'b1);
    lookup(7, 1'b0);
    do_write(7, 'h9, 1'b1);
    wait_out_valid("bucket7");
    repeat (4) tick();
    $display("bucket 7 late write done");

    // Write to a bucket whose beat is parked in the FIFO.
    do_write(2, 'h2a, 1'b1);
    pdata_out_ready_i = 1'b0;
    lookup(2, 1'b0);
    wait_out_valid("bucket2");
    do_write(2, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (pdata_out_valid_o !== 1'b1 || head_ptr_val_o !== 1'b0) begin
      errors++;
      $display("FAIL parked_update: valid=%0b val=%0b required valid=1 val=0",
               pdata_out_valid_o, head_ptr_val_o);
    end
    pdata_out_ready_i = 1'b1;
    tick();
    repeat (4) tick();
    $display("bucket 2 parked update done");

    // Reset with beats buffered.
    pdata_out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) lookup($urandom_range(0, 15), 1'b0);
    repeat (4) tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if (pdata_out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: out_valid got %0b required 0", pdata_out_valid_o);
    end
    repeat (2) tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (pdata_in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_midreset: got %0b required 1", pdata_in_ready_o);
    end
    pdata_out_ready_i = 1'b1;
    repeat (10) tick();
    $display("mid-operation reset done");

    // Random traffic with colliding buckets and concurrent writes.
    for (int i = 0; i < 3000; i++) begin
      pdata_in_valid_i = 1'($urandom_range(0, 2) != 0);
      bucket_in_i = BW'($urandom_range(0, 15));
      pdata_in_i = {$urandom, $urandom};
      pdata_out_ready_i = ((i / 50) % 3 == 2) ? 1'($urandom_range(0, 4) == 0)
                                               : 1'($urandom_range(0, 3) != 0);
      ht_wr_en_i = 1'($urandom_range(0, 9) < 3);
      ht_wr_addr_i = BW'($urandom_range(0, 15));
      ht_wr_data_ptr_i = PW'($urandom);
      ht_wr_data_ptr_val_i = 1'($urandom);
      tick();
    end
    pdata_in_valid_i = 1'b0;
    ht_wr_en_i = 1'b0;
    pdata_out_ready_i = 1'b1;
    repeat (20) tick();
    $display("random phase done, acc_count=%0d", acc_count);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats left required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
